// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port, cacheline-granular arbiter in front of one line adaptor.
// One line transaction is outstanding at a time. The winner is picked round-robin
// (PRIORITY_MODE=0) or by fixed priority with port 0 highest (PRIORITY_MODE=1).
// The winning request is latched, so clients may change their inputs after the grant.
// A one-cycle RELEASE state follows every completion, so a client that still holds
// its request in the completion cycle is not granted again by mistake.
// Optional feature macro: MEM_ARB_RESP_REG_EN. When defined, the response path is
// registered: an extra RESP state drives cli_resp and cli_rdata from flops.
`timescale 1ns/1ps
module mem_arbiter_n #(
    parameter int N_PORTS       = 2,
    parameter int LINE_W        = 256,
    parameter int ADDR_W        = 32,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [N_PORTS-1:0]               cli_read,
    input  logic [N_PORTS-1:0]               cli_write,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]   cli_address,
    input  logic [N_PORTS-1:0][LINE_W-1:0]   cli_wdata,
    output logic [LINE_W-1:0]                cli_rdata,
    output logic [N_PORTS-1:0]               cli_resp,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_W-1:0]                mem_address,
    output logic [LINE_W-1:0]                mem_wdata,
    input  logic [LINE_W-1:0]                mem_rdata,
    input  logic                             mem_resp
);

    // Handshake: a client raises cli_read or cli_write and holds it (with a stable
    // address/line) until its one-cycle cli_resp pulse; towards the adaptor,
    // mem_read/mem_write stay high until and including the cycle mem_resp is seen,
    // and mem_resp is honoured only while a transaction is in flight.

    localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int SCAN_W = IDX_W + 1;

`ifdef MEM_ARB_RESP_REG_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESP    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd3
    } state_t;
`endif

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_q;
    logic [IDX_W-1:0]   next_ptr;

    logic [N_PORTS-1:0] req;
    logic               any_req;
    logic [IDX_W-1:0]   win_idx;
    logic               found;
    logic [SCAN_W-1:0]  scan;

`ifdef MEM_ARB_RESP_REG_EN
    logic [N_PORTS-1:0] resp_q;
    logic [LINE_W-1:0]  rdata_q;
`endif

    // Pick this cycle's winner: scan from rr_ptr (round-robin) or from 0 (fixed).
    always_comb begin
        req     = cli_read | cli_write;
        any_req = |req;
        win_idx = '0;
        found   = 1'b0;
        scan    = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (PRIORITY_MODE != 0) begin
                scan = SCAN_W'(k);
            end else begin
                scan = {1'b0, rr_ptr} + SCAN_W'(k);
                if (scan >= SCAN_W'(N_PORTS)) begin
                    scan = scan - SCAN_W'(N_PORTS);
                end
            end
            if (!found && req[scan[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = scan[IDX_W-1:0];
            end
        end
    end

    // The port after the current winner, wrapping at N_PORTS.
    assign next_ptr = (win_q == IDX_W'(N_PORTS - 1)) ? '0 : win_q + IDX_W'(1);

    // Arbitration FSM; every adaptor-side output is registered here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            win_q       <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
`ifdef MEM_ARB_RESP_REG_EN
            resp_q      <= '0;
            rdata_q     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        // A write wins over a read raised on the same port.
                        win_q       <= win_idx;
                        mem_write   <= cli_write[win_idx];
                        mem_read    <= ~cli_write[win_idx];
                        mem_address <= cli_address[win_idx];
                        mem_wdata   <= cli_wdata[win_idx];
                        state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Client inputs are ignored here; only the adaptor can end this.
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (PRIORITY_MODE == 0) begin
                            rr_ptr <= next_ptr;
                        end
`ifdef MEM_ARB_RESP_REG_EN
                        rdata_q         <= mem_rdata;
                        resp_q          <= '0;
                        resp_q[win_q]   <= 1'b1;
                        state           <= S_RESP;
`else
                        state           <= S_RELEASE;
`endif
                    end
                end
`ifdef MEM_ARB_RESP_REG_EN
                S_RESP: begin
                    resp_q <= '0;
                    state  <= S_RELEASE;
                end
`endif
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_RESP_REG_EN
    assign cli_resp  = resp_q;
    assign cli_rdata = rdata_q;
`else
    // Completion passes straight through to the winning port in the mem_resp cycle.
    always_comb begin
        cli_resp = '0;
        if (reset_n && (state == S_BUSY) && mem_resp) begin
            cli_resp[win_q] = 1'b1;
        end
    end
    assign cli_rdata = mem_rdata;
`endif

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed bench for mem_arbiter_n with two instances:
// a 4-port round-robin arbiter and a 4-port fixed-priority arbiter.
// Builds with or without MEM_ARB_RESP_REG_EN; response timing adapts to the macro.
`timescale 1ns/1ps
module tb_mem_arbiter_n;

    localparam int NP = 4;
    localparam int LW = 64;
    localparam int AW = 32;
`ifdef MEM_ARB_RESP_REG_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 2;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // round-robin instance signals
    logic [NP-1:0]         rr_read, rr_write, rr_resp;
    logic [NP-1:0][AW-1:0] rr_addr;
    logic [NP-1:0][LW-1:0] rr_wdata;
    logic [LW-1:0]         rr_rdata, rr_mwdata, rr_mrdata;
    logic [AW-1:0]         rr_maddr;
    logic                  rr_mread, rr_mwrite, rr_mresp;

    // fixed-priority instance signals
    logic [NP-1:0]         fp_read, fp_write, fp_resp;
    logic [NP-1:0][AW-1:0] fp_addr;
    logic [NP-1:0][LW-1:0] fp_wdata;
    logic [LW-1:0]         fp_rdata, fp_mwdata, fp_mrdata;
    logic [AW-1:0]         fp_maddr;
    logic                  fp_mread, fp_mwrite, fp_mresp;

    int n_checks = 0;
    int n_fail   = 0;
    int fp_wait;

    mem_arbiter_n #(.N_PORTS(NP), .LINE_W(LW), .ADDR_W(AW), .PRIORITY_MODE(0)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .cli_read(rr_read), .cli_write(rr_write),
        .cli_address(rr_addr), .cli_wdata(rr_wdata),
        .cli_rdata(rr_rdata), .cli_resp(rr_resp),
        .mem_read(rr_mread), .mem_write(rr_mwrite),
        .mem_address(rr_maddr), .mem_wdata(rr_mwdata),
        .mem_rdata(rr_mrdata), .mem_resp(rr_mresp)
    );

    mem_arbiter_n #(.N_PORTS(NP), .LINE_W(LW), .ADDR_W(AW), .PRIORITY_MODE(1)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .cli_read(fp_read), .cli_write(fp_write),
        .cli_address(fp_addr), .cli_wdata(fp_wdata),
        .cli_rdata(fp_rdata), .cli_resp(fp_resp),
        .mem_read(fp_mread), .mem_write(fp_mwrite),
        .mem_address(fp_maddr), .mem_wdata(fp_mwdata),
        .mem_rdata(fp_mrdata), .mem_resp(fp_mresp)
    );

    // scoreboard compare
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int k);
        return {8{8'hA5}} ^ 64'(k);
    endfunction

    // wait (bounded) for the round-robin instance to start a transaction
    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (!(rr_mread || rr_mwrite) && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(rr_mread | rr_mwrite), 64'd1);
    endtask

    // act as the adaptor for one granted transaction: respond after 5 cycles,
    // check the response, then measure the idle gap to the next grant
    task automatic rr_serve(input logic [AW-1:0] exp_addr, input int port,
                            input logic [LW-1:0] exp_wdata, input logic [LW-1:0] p,
                            input bit last);
        int idle;
        check("rr_grant_addr", 64'(rr_maddr), 64'(exp_addr));
        repeat (4) tick();
        check("rr_req_held", 64'(rr_mread | rr_mwrite), 64'd1);
        check("rr_addr_held", 64'(rr_maddr), 64'(exp_addr));
        check("rr_wdata_held", rr_mwdata, exp_wdata);
        rr_mresp  = 1'b1;
        rr_mrdata = p;
        if (last) begin
            rr_read  = '0;
            rr_write = '0;
        end
        #1;
`ifndef MEM_ARB_RESP_REG_EN
        check("rr_resp_bit", 64'(rr_resp), 64'(1) << port);
        check("rr_rdata", rr_rdata, p);
`endif
        tick();
        rr_mresp  = 1'b0;
        rr_mrdata = '0;
        #1;
`ifdef MEM_ARB_RESP_REG_EN
        check("rr_resp_bit", 64'(rr_resp), 64'(1) << port);
        check("rr_rdata", rr_rdata, p);
`endif
        check("rr_mem_drop", 64'(rr_mread | rr_mwrite), 64'd0);
        if (last) begin
            tick();
            check("rr_resp_width", 64'(rr_resp), 64'd0);
        end else begin
            idle = 0;
            while (!(rr_mread || rr_mwrite) && idle < 20) begin
                idle++;
                tick();
                if (idle == 1) check("rr_resp_width", 64'(rr_resp), 64'd0);
            end
            check("rr_idle_gap", 64'(idle), 64'(GAP));
        end
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        rr_read   = 4'b0011;
        rr_write  = '0;
        rr_mresp  = 1'b0;
        rr_mrdata = '0;
        fp_read   = '0;
        fp_write  = '0;
        fp_mresp  = 1'b0;
        fp_mrdata = '0;
        for (int i = 0; i < NP; i++) begin
            rr_addr[i]  = 32'h0000_1000 + 32'(i * 64);
            rr_wdata[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
            fp_addr[i]  = 32'h0000_2000 + 32'(i * 64);
            fp_wdata[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
        end

        // reset held two cycles with ports 0 and 1 requesting
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_mread", 64'(rr_mread), 64'd0);
            check("rst_mwrite", 64'(rr_mwrite), 64'd0);
            check("rst_maddr", 64'(rr_maddr), 64'd0);
            check("rst_mwdata", rr_mwdata, 64'd0);
            check("rst_resp", 64'(rr_resp), 64'd0);
            check("rst_fp_mread", 64'(fp_mread), 64'd0);
`ifdef MEM_ARB_RESP_REG_EN
            check("rst_rdata", rr_rdata, 64'd0);
`endif
        end
        reset_n = 1'b1;
        tick();
        check("rst_first_grant", 64'(rr_mread), 64'd1);
        check("rst_first_addr", 64'(rr_maddr), 64'(rr_addr[0]));

        // round-robin fairness: all ports reading, expected order 0,1,2,3,0
        rr_read = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            rr_serve(rr_addr[g % 4], g % 4, rr_wdata[g % 4], pat(g), g == 4);
        end

        // latch integrity: port 1 write, inputs changed mid-transaction
        repeat (2) tick();
        rr_addr[1]  = 32'h0000_1240;
        rr_wdata[1] = 64'hCAFE_F00D_1234_5678;
        rr_write    = 4'b0010;
        wait_grant("latch_grant");
        check("latch_mwrite", 64'(rr_mwrite), 64'd1);
        check("latch_mread", 64'(rr_mread), 64'd0);
        check("latch_wdata", rr_mwdata, 64'hCAFE_F00D_1234_5678);
        rr_addr[1]  = 32'hDEAD_0000;
        rr_wdata[1] = 64'h0;
        rr_write    = 4'b0000;
        rr_serve(32'h0000_1240, 1, 64'hCAFE_F00D_1234_5678, pat(5), 1'b1);

        // spurious mem_resp while idle
        repeat (2) tick();
        rr_mresp  = 1'b1;
        rr_mrdata = pat(9);
        #1;
        check("spur_resp_now", 64'(rr_resp), 64'd0);
        tick();
        rr_mresp  = 1'b0;
        rr_mrdata = '0;
        #1;
        check("spur_resp_next", 64'(rr_resp), 64'd0);
        check("spur_mem_idle", 64'(rr_mread | rr_mwrite), 64'd0);

        // read and write together on port 2: write is taken
        rr_addr[1]  = 32'h0000_1040;
        rr_wdata[1] = 64'h2222_2222_2222_2222;
        rr_read     = 4'b0100;
        rr_write    = 4'b0100;
        wait_grant("rw_grant");
        check("rw_mwrite", 64'(rr_mwrite), 64'd1);
        check("rw_mread", 64'(rr_mread), 64'd0);
        rr_serve(rr_addr[2], 2, rr_wdata[2], pat(6), 1'b1);

        // reset during BUSY: pointer back to 0, so port 1 wins over port 3
        repeat (2) tick();
        rr_read = 4'b1010;
        wait_grant("rstb_grant");
        check("rstb_grant_addr", 64'(rr_maddr), 64'(rr_addr[3]));
        tick();
        reset_n = 1'b0;
        tick();
        check("rstb_mread_drop", 64'(rr_mread), 64'd0);
        check("rstb_maddr", 64'(rr_maddr), 64'd0);
        reset_n = 1'b1;
        wait_grant("rstb_regrant");
        check("rstb_ptr_zero", 64'(rr_maddr), 64'(rr_addr[1]));
        rr_serve(rr_addr[1], 1, rr_wdata[1], pat(7), 1'b1);

        // fixed priority: ports 0 and 2 continuously reading, port 0 always wins
        fp_read = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            fp_wait = 0;
            while (!fp_mread && fp_wait < 20) begin
                tick();
                fp_wait++;
            end
            check("fp_grant", 64'(fp_mread), 64'd1);
            check("fp_grant_addr", 64'(fp_maddr), 64'(fp_addr[0]));
            repeat (2) tick();
            fp_mresp  = 1'b1;
            fp_mrdata = pat(20 + k);
            if (k == 2) fp_read = '0;
            #1;
`ifndef MEM_ARB_RESP_REG_EN
            check("fp_resp", 64'(fp_resp), 64'd1);
            check("fp_rdata", fp_rdata, pat(20 + k));
`endif
            tick();
            fp_mresp  = 1'b0;
            fp_mrdata = '0;
            #1;
`ifdef MEM_ARB_RESP_REG_EN
            check("fp_resp", 64'(fp_resp), 64'd1);
            check("fp_rdata", fp_rdata, pat(20 + k));
`endif
        end
        repeat (4) tick();
        check("fp_end_idle", 64'(fp_mread | fp_mwrite), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
